io_sequencer: RTL

- Multi-cycle sequencer for the processor's IN, OUT and HLT opcodes.
- Stalls the PC and register-file write path while an external input source or output display completes a valid/ready handshake.
- Latches HLT into a sticky halted state.
- Sits beside the combinational control unit. It consumes the same 5-bit OpCode and gates that unit's RegWrite/OutWrite effects.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/io_sequencer_if.sv | 11 +
 rtl/io_timeout_counter.sv | 18 +
 rtl/io_sequencer.sv | 71 +++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, data width and I/O sequencer state shared by the control unit and io_sequencer.
package cpu_pkg;
    localparam int DATA_W = 32;
    localparam logic [4:0] OP_IN  = 5'b01011;
    localparam logic [4:0] OP_OUT = 5'b01100;
    localparam logic [4:0] OP_HLT = 5'b11000;
    typedef enum logic [2:0] {IDLE, WAIT_IN, IN_DONE, WAIT_OUT, OUT_DONE, HALTED} io_state_t;
    function automatic logic is_io_op(input logic [4:0] op);
        return op == OP_IN || op == OP_OUT || op == OP_HLT;
    endfunction
endpackage

// File: rtl/io_sequencer_if.sv
// io_sequencer_if: valid/ready handshakes between the sequencer (master) and the input source / output display (slave).
interface io_sequencer_if #(parameter int W = cpu_pkg::DATA_W);
    logic         InValid;
    logic [W-1:0] InData;
    logic         InAck;
    logic         OutValid;
    logic         OutReady;
    logic [W-1:0] OutWord;
    modport master(input InValid, InData, OutReady, output InAck, OutValid, OutWord);
    modport slave(output InValid, InData, OutReady, input InAck, OutValid, OutWord);
endinterface

// File: rtl/io_timeout_counter.sv
// io_timeout_counter: cycle counter with synchronous clear that saturates at MAX-1 and flags it on tc.
module io_timeout_counter #(
    parameter int MAX = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam int W = MAX > 1 ? $clog2(MAX) : 1;
    logic [W-1:0] cnt;
    always_ff @(posedge clock or negedge reset)
        if (!reset) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (enable && !tc) cnt <= cnt + 1'b1;
    assign tc = cnt == W'(MAX - 1);
endmodule

// File: rtl/io_sequencer.sv
// io_sequencer: stalls the pipeline across IN/OUT handshakes and latches HLT.
// Define IO_TIMEOUT_EN to abort an OUT after TIMEOUT_CYC unanswered cycles and flag IoError.
module io_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W      = cpu_pkg::DATA_W,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [4:0]        OpCode,
    io_sequencer_if.master    io,
    output logic [DATA_W-1:0] InWord,
    output logic              InWrite,
    input  logic [DATA_W-1:0] OutSrc,
    output logic              Stall,
    output logic              Halted,
    output logic              IoError
);
    io_state_t state;
    logic      timeout;
    // InAck is combinational so it marks the very clock that captures InData
    assign io.InAck = state == WAIT_IN && io.InValid;
    assign InWrite  = state == IN_DONE;
    assign Halted   = state == HALTED;
    assign Stall    = state inside {WAIT_IN, WAIT_OUT, HALTED} || (state == IDLE && is_io_op(OpCode));
`ifdef IO_TIMEOUT_EN
    io_timeout_counter #(.MAX(TIMEOUT_CYC)) u_timeout (
        .clock (clock),
        .reset (reset),
        .clear (state != WAIT_OUT),
        .enable(state == WAIT_OUT),
        .tc    (timeout)
    );
`else
    // no timeout in this build; the comparison is constant false
    assign timeout = TIMEOUT_CYC < 0;
`endif
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            InWord      <= '0;
            io.OutWord  <= '0;
            io.OutValid <= 1'b0;
            IoError     <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (OpCode == OP_IN) state <= WAIT_IN;
                    else if (OpCode == OP_OUT) begin
                        io.OutWord  <= OutSrc;
                        io.OutValid <= 1'b1;
                        state       <= WAIT_OUT;
                    end else if (OpCode == OP_HLT) state <= HALTED;
                WAIT_IN:
                    if (io.InValid) begin
                        InWord <= io.InData;
                        state  <= IN_DONE;
                    end
                WAIT_OUT:
                    if (io.OutReady || timeout) begin
                        io.OutValid <= 1'b0;
                        IoError     <= IoError | !io.OutReady;
                        state       <= OUT_DONE;
                    end
                HALTED:  state <= HALTED;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
